// File: rtl/analogue_pkg.sv
// Shared types and constants for the analogue channel edge trigger.
package analogue_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRE     = 2'd1,
    ST_READY   = 2'd2,
    ST_HOLDOFF = 2'd3
  } trig_state_t;

endpackage

// File: rtl/sat_addsub.sv
// Saturating level -/+ hysteresis, one bit wider internally so the carry/borrow
// selects the clamp value.
module sat_addsub #(
  parameter int W = 16
) (
  input  logic [W-1:0] level,
  input  logic [W-1:0] hyst,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic [W:0] diff;
  logic [W:0] sum;

  assign diff = {1'b0, level} - {1'b0, hyst};
  assign sum  = {1'b0, level} + {1'b0, hyst};

  // A borrow sets the top bit of diff; a carry sets the top bit of sum.
  assign lo = diff[W] ? '0 : diff[W-1:0];
  assign hi = sum[W]  ? '1 : sum[W-1:0];

endmodule

// File: rtl/analogue_edge_trigger.sv
// Level/hysteresis edge trigger with sample-counted holdoff and optional
// auto-trigger timeout for the MSO analogue channel.
module analogue_edge_trigger
  import analogue_pkg::*;
#(
  parameter int                DATA_W       = DEFAULT_DATA_W,
  parameter int                HOLDOFF_W    = 16,
  parameter int                AUTO_W       = 20,
  parameter logic [AUTO_W-1:0] AUTO_TIMEOUT = AUTO_W'(100000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    sample,
  input  logic                 sample_valid,
  input  logic                 arm,
  input  logic                 auto_en,
  input  logic                 slope,
  input  logic [DATA_W-1:0]    level,
  input  logic [DATA_W-1:0]    hyst,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic                 trig,
  output logic                 trig_auto,
  output logic                 armed
);

  // Count value that, when one more valid sample arrives, reaches the timeout.
  localparam logic [AUTO_W-1:0] TMO_LAST = AUTO_TIMEOUT - AUTO_W'(1);

  trig_state_t           state, state_next;
  logic [DATA_W-1:0]     level_s, hyst_s;
  logic                  slope_s;
  logic [HOLDOFF_W-1:0]  holdoff_s;
  logic [HOLDOFF_W-1:0]  hold_cnt, hold_next;
  logic [AUTO_W-1:0]     tmo_cnt, tmo_next;
  logic                  trig_next, auto_next, latch_cfg, fire;
  logic [DATA_W-1:0]     lo, hi;
  logic                  pre_met, crossed;

  sat_addsub #(.W(DATA_W)) u_thresh (
    .level (level_s),
    .hyst  (hyst_s),
    .lo    (lo),
    .hi    (hi)
  );

  always_comb begin
    if (slope_s == SLOPE_FALL) begin
      pre_met = (sample >= hi);
      crossed = (sample <= level_s);
    end else begin
      pre_met = (sample <= lo);
      crossed = (sample >= level_s);
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case tree can leave one unassigned and infer a latch.
    state_next = state;
    hold_next  = hold_cnt;
    tmo_next   = tmo_cnt;
    trig_next  = 1'b0;
    auto_next  = 1'b0;
    latch_cfg  = 1'b0;
    fire       = 1'b0;

    if (!arm) begin
      state_next = ST_IDLE;
      hold_next  = '0;
      tmo_next   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_next = ST_PRE;
          latch_cfg  = 1'b1;
          hold_next  = '0;
          tmo_next   = '0;
        end
        ST_PRE, ST_READY: begin
          if (sample_valid) begin
            // A real crossing outranks a timeout on the same sample; a sample
            // meeting the pre-condition in PRE only advances to READY.
            if (state == ST_READY && crossed) begin
              fire = 1'b1;
            end else if (auto_en && tmo_cnt >= TMO_LAST) begin
              fire      = 1'b1;
              auto_next = 1'b1;
            end else begin
              if (auto_en) tmo_next = tmo_cnt + AUTO_W'(1);
              if (state == ST_PRE && pre_met) state_next = ST_READY;
            end
          end
        end
        ST_HOLDOFF: begin
          tmo_next = '0;
          if (hold_cnt == '0) begin
            state_next = ST_PRE;
          end else if (sample_valid) begin
            hold_next = hold_cnt - HOLDOFF_W'(1);
            if (hold_cnt == HOLDOFF_W'(1)) state_next = ST_PRE;
          end
        end
        default: state_next = ST_IDLE;
      endcase

      if (fire) begin
        state_next = ST_HOLDOFF;
        hold_next  = holdoff_s;
        tmo_next   = '0;
        trig_next  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
      trig      <= 1'b0;
      trig_auto <= 1'b0;
      level_s   <= '0;
      hyst_s    <= '0;
      slope_s   <= SLOPE_RISE;
      holdoff_s <= '0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      tmo_cnt   <= tmo_next;
      trig      <= trig_next;
      trig_auto <= auto_next;
      if (latch_cfg) begin
        level_s   <= level;
        hyst_s    <= hyst;
        slope_s   <= slope;
        holdoff_s <= holdoff;
      end
    end
  end

  assign armed = (state != ST_IDLE);

endmodule
